// File: rtl/fp16_cmp_sched_if.sv
// Requester, response and comparator signals of the fp16 compare scheduler.
// The slave side is the scheduler; the master side is its environment.
interface fp16_cmp_sched_if;
  logic        req0_valid;
  logic        req1_valid;
  logic        req0_ready;
  logic        req1_ready;
  logic [15:0] req0_x;
  logic [15:0] req0_y;
  logic [15:0] req1_x;
  logic [15:0] req1_y;
  logic        rsp0_valid;
  logic        rsp1_valid;
  logic [2:0]  rsp_result;
  logic        cmp_start;
  logic [15:0] cmp_x;
  logic [15:0] cmp_y;
  logic        cmp_done;
  logic [2:0]  cmp_result;
  logic        busy;
  logic        timeout_err;

  modport slave (
    input  req0_valid, req1_valid, req0_x, req0_y, req1_x, req1_y,
           cmp_done, cmp_result,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result,
           cmp_start, cmp_x, cmp_y, busy, timeout_err
  );

  modport master (
    output req0_valid, req1_valid, req0_x, req0_y, req1_x, req1_y,
           cmp_done, cmp_result,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result,
           cmp_start, cmp_x, cmp_y, busy, timeout_err
  );
endinterface

// File: rtl/fp16_cmp_sched.sv
// Two-requester round-robin scheduler in front of a shared multi-cycle fp16
// comparator, with a per-compare timeout that aborts with result 000.
module fp16_cmp_sched #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  fp16_cmp_sched_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t      state;
  logic        last_grant;
  logic        owner;
  logic [15:0] x_q;
  logic [15:0] y_q;
  logic [7:0]  cnt;
  logic [2:0]  result_q;
  logic        start_q;
  logic        rsp0_q;
  logic        rsp1_q;
  logic        tmo_q;
  logic        grant_any;
  logic        grant_idx;
  logic        accept;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_any = 1'b1;
      grant_idx = ~last_grant;
    end else if (bus.req0_valid) begin
      grant_any = 1'b1;
      grant_idx = 1'b0;
    end else if (bus.req1_valid) begin
      grant_any = 1'b1;
      grant_idx = 1'b1;
    end
  end

  assign accept         = (state == IDLE) && grant_any && !reset;
  assign bus.req0_ready = accept && !grant_idx;
  assign bus.req1_ready = accept && grant_idx;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      cnt        <= '0;
      result_q   <= '0;
      start_q    <= 1'b0;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      start_q <= 1'b0;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
      tmo_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner   <= grant_idx;
            x_q     <= grant_idx ? bus.req1_x : bus.req0_x;
            y_q     <= grant_idx ? bus.req1_y : bus.req0_y;
            start_q <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 8'd1;
          // A completion in the timeout cycle still wins over the abort.
          if (bus.cmp_done) begin
            result_q <= bus.cmp_result;
            rsp0_q   <= ~owner;
            rsp1_q   <= owner;
            state    <= RESP;
          end else if (cnt == TMO) begin
            result_q <= 3'b000;
            tmo_q    <= 1'b1;
            rsp0_q   <= ~owner;
            rsp1_q   <= owner;
            state    <= RESP;
          end
        end
        RESP: begin
          last_grant <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are masked while reset is held so none leaks in the first reset cycle.
  assign bus.cmp_start   = start_q && !reset;
  assign bus.rsp0_valid  = rsp0_q && !reset;
  assign bus.rsp1_valid  = rsp1_q && !reset;
  assign bus.timeout_err = tmo_q && !reset;
  assign bus.cmp_x       = x_q;
  assign bus.cmp_y       = y_q;
  assign bus.rsp_result  = result_q;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_fp16_cmp_sched.sv
// Directed bench for fp16_cmp_sched built with TIMEOUT=3: latency, round-robin
// ties, timeout, done/timeout coincidence, reset mid-compare and stray done.
module tb_fp16_cmp_sched;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  fp16_cmp_sched_if bus();

  fp16_cmp_sched #(.TIMEOUT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    reset = 1'b1;
    step();
    step();
    #1;
    checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b%b exp=00", bus.req0_ready, bus.req1_ready); end
    checks++; if (bus.cmp_start !== 1'b0) begin failures++; $display("FAIL reset_cmp_start got=%b exp=0", bus.cmp_start); end
    checks++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp got=%b%b exp=00", bus.rsp0_valid, bus.rsp1_valid); end
    checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err got=%b exp=0", bus.timeout_err); end
    checks++; if (bus.rsp_result !== 3'b000) begin failures++; $display("FAIL reset_rsp_result got=%b exp=000", bus.rsp_result); end
    checks++; if (bus.cmp_x !== 16'h0 || bus.cmp_y !== 16'h0) begin failures++; $display("FAIL reset_operands got=%h/%h exp=0000/0000", bus.cmp_x, bus.cmp_y); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    step();
    bus.req0_valid = 1'b1; bus.req0_x = 16'h3C00; bus.req0_y = 16'h4000;
    #1;
    checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin failures++; $display("FAIL single_ready got=%b%b exp=10", bus.req0_ready, bus.req1_ready); end
    step(); // T+1
    bus.req0_valid = 1'b0;
    #1;
    checks++; if (bus.cmp_start !== 1'b1) begin failures++; $display("FAIL single_start got=%b exp=1", bus.cmp_start); end
    checks++; if (bus.cmp_x !== 16'h3C00 || bus.cmp_y !== 16'h4000) begin failures++; $display("FAIL single_operands got=%h/%h exp=3c00/4000", bus.cmp_x, bus.cmp_y); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    step(); // T+2
    #1;
    checks++; if (bus.cmp_start !== 1'b0) begin failures++; $display("FAIL single_start_pulse got=%b exp=0", bus.cmp_start); end
    step(); // T+3
    bus.cmp_done = 1'b1; bus.cmp_result = 3'b100;
    #1;
    checks++; if (bus.rsp0_valid !== 1'b0) begin failures++; $display("FAIL single_rsp_early got=%b exp=0", bus.rsp0_valid); end
    checks++; if (bus.cmp_x !== 16'h3C00) begin failures++; $display("FAIL single_hold_x got=%h exp=3c00", bus.cmp_x); end
    step(); // T+4
    bus.cmp_done = 1'b0;
    #1;
    checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0) begin failures++; $display("FAIL single_rsp got=%b%b exp=10", bus.rsp0_valid, bus.rsp1_valid); end
    checks++; if (bus.rsp_result !== 3'b100) begin failures++; $display("FAIL single_result got=%b exp=100", bus.rsp_result); end
    checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL single_timeout_err got=%b exp=0", bus.timeout_err); end
    step(); // T+5
    #1;
    checks++; if (bus.rsp0_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL single_idle got rsp0=%b busy=%b exp=0/0", bus.rsp0_valid, bus.busy); end
    checks++; if (bus.rsp_result !== 3'b100) begin failures++; $display("FAIL single_result_hold got=%b exp=100", bus.rsp_result); end
  endtask

  task automatic test_tie();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step(); // T
    bus.req0_valid = 1'b1; bus.req0_x = 16'h4000; bus.req0_y = 16'h3C00;
    bus.req1_valid = 1'b1; bus.req1_x = 16'hC000; bus.req1_y = 16'h0000;
    #1;
    checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin failures++; $display("FAIL tie1_ready got=%b%b exp=10", bus.req0_ready, bus.req1_ready); end
    step(); // T+1
    bus.req0_valid = 1'b0;
    #1;
    checks++; if (bus.req1_ready !== 1'b0) begin failures++; $display("FAIL tie_no_accept_busy got=%b exp=0", bus.req1_ready); end
    checks++; if (bus.cmp_start !== 1'b1 || bus.cmp_x !== 16'h4000) begin failures++; $display("FAIL tie1_start got start=%b x=%h exp=1/4000", bus.cmp_start, bus.cmp_x); end
    step(); // T+2
    bus.cmp_done = 1'b1; bus.cmp_result = 3'b010;
    step(); // T+3
    bus.cmp_done = 1'b0;
    #1;
    checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0) begin failures++; $display("FAIL tie1_rsp got=%b%b exp=10", bus.rsp0_valid, bus.rsp1_valid); end
    checks++; if (bus.rsp_result !== 3'b010) begin failures++; $display("FAIL tie1_result got=%b exp=010", bus.rsp_result); end
    step(); // T+4
    #1;
    checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1) begin failures++; $display("FAIL tie2_ready got=%b%b exp=01", bus.req0_ready, bus.req1_ready); end
    step(); // T+5
    bus.req1_valid = 1'b0;
    #1;
    checks++; if (bus.cmp_start !== 1'b1 || bus.cmp_x !== 16'hC000 || bus.cmp_y !== 16'h0000) begin failures++; $display("FAIL tie2_start got start=%b x=%h y=%h exp=1/c000/0000", bus.cmp_start, bus.cmp_x, bus.cmp_y); end
    step(); // T+6
    bus.cmp_done = 1'b1; bus.cmp_result = 3'b100;
    step(); // T+7
    bus.cmp_done = 1'b0;
    #1;
    checks++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b1) begin failures++; $display("FAIL tie2_rsp got=%b%b exp=01", bus.rsp0_valid, bus.rsp1_valid); end
    checks++; if (bus.rsp_result !== 3'b100) begin failures++; $display("FAIL tie2_result got=%b exp=100", bus.rsp_result); end
    step(); // T+8
    bus.req0_valid = 1'b1; bus.req0_x = 16'h3800; bus.req0_y = 16'h3800;
    bus.req1_valid = 1'b1;
    #1;
    checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin failures++; $display("FAIL tie3_ready got=%b%b exp=10", bus.req0_ready, bus.req1_ready); end
    step(); // T+9
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    step(); // T+10
    bus.cmp_done = 1'b1; bus.cmp_result = 3'b001;
    step(); // T+11
    bus.cmp_done = 1'b0;
    #1;
    checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp_result !== 3'b001) begin failures++; $display("FAIL tie3_rsp got rsp0=%b result=%b exp=1/001", bus.rsp0_valid, bus.rsp_result); end
  endtask

  task automatic test_timeout();
    step(); // T
    bus.req1_valid = 1'b1; bus.req1_x = 16'h1234; bus.req1_y = 16'h5678;
    #1;
    checks++; if (bus.req1_ready !== 1'b1) begin failures++; $display("FAIL tmo_ready got=%b exp=1", bus.req1_ready); end
    step(); // T+1
    bus.req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) step(); // WAIT with counter 0..3
    #1;
    checks++; if (bus.timeout_err !== 1'b0 || bus.rsp1_valid !== 1'b0) begin failures++; $display("FAIL tmo_early got err=%b rsp1=%b exp=0/0", bus.timeout_err, bus.rsp1_valid); end
    checks++; if (bus.cmp_x !== 16'h1234 || bus.cmp_y !== 16'h5678) begin failures++; $display("FAIL tmo_hold got=%h/%h exp=1234/5678", bus.cmp_x, bus.cmp_y); end
    step(); // T+6
    #1;
    checks++; if (bus.timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_err got=%b exp=1", bus.timeout_err); end
    checks++; if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0) begin failures++; $display("FAIL tmo_rsp got=%b%b exp=01", bus.rsp0_valid, bus.rsp1_valid); end
    checks++; if (bus.rsp_result !== 3'b000) begin failures++; $display("FAIL tmo_result got=%b exp=000", bus.rsp_result); end
    step(); // T+7
    #1;
    checks++; if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL tmo_idle got err=%b busy=%b exp=0/0", bus.timeout_err, bus.busy); end
  endtask

  task automatic test_coincide();
    step(); // T
    bus.req0_valid = 1'b1; bus.req0_x = 16'h7BFF; bus.req0_y = 16'h7BFF;
    step(); // T+1
    bus.req0_valid = 1'b0;
    step(); step(); step(); // WAIT counter 0..2
    step(); // T+5, counter reaches TIMEOUT
    bus.cmp_done = 1'b1; bus.cmp_result = 3'b001;
    step(); // T+6
    bus.cmp_done = 1'b0;
    #1;
    checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp_result !== 3'b001) begin failures++; $display("FAIL coin_rsp got rsp0=%b result=%b exp=1/001", bus.rsp0_valid, bus.rsp_result); end
    checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL coin_err got=%b exp=0", bus.timeout_err); end
  endtask

  task automatic test_reset_mid_wait();
    step(); // T
    bus.req0_valid = 1'b1; bus.req0_x = 16'h4400; bus.req0_y = 16'h4200;
    step(); // T+1
    bus.req0_valid = 1'b0;
    step(); // T+2 in WAIT
    reset = 1'b1;
    step(); // T+3
    reset = 1'b0;
    bus.cmp_done = 1'b1; bus.cmp_result = 3'b010;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.cmp_x !== 16'h0) begin failures++; $display("FAIL rmw_cleared got busy=%b x=%h exp=0/0000", bus.busy, bus.cmp_x); end
    step(); // T+4
    bus.cmp_done = 1'b0;
    #1;
    checks++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL rmw_stray got rsp=%b%b busy=%b exp=00/0", bus.rsp0_valid, bus.rsp1_valid, bus.busy); end
    checks++; if (bus.rsp_result !== 3'b000) begin failures++; $display("FAIL rmw_result got=%b exp=000", bus.rsp_result); end
    step(); // T+5
    bus.req0_valid = 1'b1;
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin failures++; $display("FAIL rmw_ready got=%b exp=1", bus.req0_ready); end
    step(); // T+6
    bus.req0_valid = 1'b0;
    #1;
    checks++; if (bus.cmp_start !== 1'b1 || bus.cmp_x !== 16'h4400) begin failures++; $display("FAIL rmw_start got start=%b x=%h exp=1/4400", bus.cmp_start, bus.cmp_x); end
    step(); // T+7
    bus.cmp_done = 1'b1; bus.cmp_result = 3'b011;
    step(); // T+8
    bus.cmp_done = 1'b0;
    #1;
    checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp_result !== 3'b011) begin failures++; $display("FAIL rmw_rsp got rsp0=%b result=%b exp=1/011", bus.rsp0_valid, bus.rsp_result); end
  endtask

  task automatic test_spurious();
    step();
    bus.cmp_done = 1'b1; bus.cmp_result = 3'b100;
    for (int i = 0; i < 2; i++) begin
      step();
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin failures++; $display("FAIL spur_state got busy=%b rsp=%b%b exp=0/00", bus.busy, bus.rsp0_valid, bus.rsp1_valid); end
      checks++; if (bus.rsp_result !== 3'b011) begin failures++; $display("FAIL spur_result got=%b exp=011", bus.rsp_result); end
    end
    bus.cmp_done = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_x = '0; bus.req0_y = '0; bus.req1_x = '0; bus.req1_y = '0;
    bus.cmp_done = 1'b0; bus.cmp_result = '0;
    test_reset();
    test_single();
    test_tie();
    test_timeout();
    test_coincide();
    test_reset_mid_wait();
    test_spurious();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fp16_cmp_sched.md
FP16_CMP_SCHED -- requirements
Module: fp16_cmp_sched

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum WAIT cycles before a compare is aborted (legal range 1..255).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have ports req0_valid, req1_valid  input  1 each  requester has a compare pending.
REQ-005 The block SHALL have ports req0_ready, req1_ready  output  1 each  request accepted this cycle when ready and valid are both high.
REQ-006 The block SHALL have ports req0_x, req0_y, req1_x, req1_y  input  16 each  half-precision operands.
REQ-007 The block SHALL have ports rsp0_valid, rsp1_valid  output  1 each  single-cycle result strobe to the owning requester.
REQ-008 The block SHALL have port rsp_result  output  3  compare code: 010 greater, 100 less, 001 equal, 000 aborted.
REQ-009 The block SHALL have ports cmp_start  output  1, cmp_x  output  16, cmp_y  output  16  comparator launch and operands.
REQ-010 The block SHALL have ports cmp_done  input  1, cmp_result  input  3  comparator completion strobe and code.
REQ-011 The block SHALL have ports busy  output  1  (state not IDLE) and timeout_err  output  1  (one-cycle abort strobe).

Function
REQ-012 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP and no others.
REQ-013 In IDLE, grant SHALL go to the single valid requester, or, if both are valid, to the requester not served last (round-robin pointer last_grant).
REQ-014 reqN_ready SHALL be combinational: high only in IDLE and only for the granted requester; at most one ready per cycle.
REQ-015 On acceptance, the block SHALL register x, y and the owner index, and SHALL go to ISSUE.
REQ-016 In ISSUE, cmp_start SHALL be 1 for exactly one cycle with cmp_x/cmp_y equal to the latched operands; the next state SHALL be WAIT.
REQ-017 cmp_x/cmp_y SHALL hold the latched operands from ISSUE until the block leaves WAIT.
REQ-018 In WAIT, a timeout counter SHALL reset to 0 on entry and increment each cycle.
REQ-019 In WAIT, on cmp_done=1, the block SHALL latch cmp_result unchanged (non-one-hot codes are forwarded as received) and go to RESP.
REQ-020 In WAIT, when the counter reaches TIMEOUT without cmp_done, the block SHALL latch result 000, pulse timeout_err for one cycle and go to RESP.
REQ-021 If cmp_done and the timeout occur in the same cycle, cmp_done SHALL win and timeout_err SHALL stay 0.
REQ-022 In RESP, rsp<owner>_valid SHALL be 1 for one cycle with rsp_result valid; last_grant SHALL be set to owner; the next state SHALL be IDLE.
REQ-023 rsp_result SHALL hold its value until the next RESP.
REQ-024 cmp_done in IDLE, ISSUE or RESP SHALL be ignored.
REQ-025 No new request SHALL be accepted outside IDLE; a pending valid SHALL be held by the requester.
REQ-026 Latency SHALL be: accept at cycle T, cmp_start at T+1, and rsp_valid one cycle after the cycle in which cmp_done is sampled (minimum T+3).
REQ-027 Sustained throughput SHALL be one compare per 4 cycles minimum, because IDLE is visited between transactions.

Reset
REQ-028 While reset=1 at a clock edge, the state SHALL go to IDLE and last_grant SHALL be set to 1, so requester 0 wins the first tie.
REQ-029 While reset=1 at a clock edge, rsp_result SHALL be 000, cmp_x/cmp_y SHALL be 0 and the counter SHALL be 0.
REQ-030 During reset, all strobes (cmp_start, rspN_valid, timeout_err) and all ready outputs SHALL be 0.
REQ-031 Reset asserted in any state SHALL abort the transaction with no response; a cmp_done arriving after reset is released SHALL be ignored per REQ-024.

Verification
REQ-032 Single request: req0 x=0x3C00, y=0x4000; comparator returns 100 two cycles after start -> rsp0_valid with rsp_result=100 at T+4, rsp1_valid stays 0.
REQ-033 Tie after reset: req0 and req1 valid in the same cycle -> req0 granted first, then req1; rsp0 precedes rsp1, and a third tie grants req0.
REQ-034 Timeout with TIMEOUT=3: cmp_done never asserted -> timeout_err pulse and rsp_result=000 to the owner; the block returns to IDLE.
REQ-035 Coincidence: cmp_done asserted in the cycle the counter reaches TIMEOUT with result 001 -> rsp_result=001 and timeout_err=0.
REQ-036 Reset mid-WAIT: reset for one cycle, then a stray cmp_done -> no rsp strobe, busy=0, and the next request is served normally.
REQ-037 Spurious done: cmp_done=1 in IDLE -> no state change, and rsp_result remains unchanged.
